// File: rtl/prio_enc_pipe_if.sv
// +----------------------------------------------------------------------------+
// | prio_enc_pipe_if: request/result handshake bundle for prio_enc_pipe.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface prio_enc_pipe_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = 8
);
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_zero;
  logic             out_multi;
  logic [CNT_W-1:0] err_count;
  logic             clear_count;

  modport master (
    output enable, in_valid, in_data, out_ready, clear_count,
    input  in_ready, out_valid, out_index, out_zero, out_multi, err_count
  );

  modport slave (
    input  enable, in_valid, in_data, out_ready, clear_count,
    output in_ready, out_valid, out_index, out_zero, out_multi, err_count
  );
endinterface

`default_nettype wire

// File: rtl/prio_enc_pipe.sv
// +----------------------------------------------------------------------------+
// | prio_enc_pipe: two-stage valid/ready priority encoder with multi-hot count.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module prio_enc_pipe #(
  parameter int WIDTH        = 16,
  parameter int IDX_W        = $clog2(WIDTH),
  parameter bit MSB_PRIORITY = 1'b1,
  parameter int CNT_W        = 8
) (
  input  wire logic     clock,
  input  wire logic     reset,
  prio_enc_pipe_if.slave bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_en;
  logic             s2_valid;
  logic [IDX_W-1:0] s2_index;
  logic             s2_zero;
  logic             s2_multi;
  logic [CNT_W-1:0] err_cnt;

  logic             s2_load;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic [IDX_W-1:0] enc_index;
  logic             enc_zero;
  logic             enc_multi;
  logic             any_set;

  assign s2_load  = s1_valid && (!s2_valid || bus.out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = s2_valid && bus.out_ready;

  // Single scan: later set bits overwrite the index only under MSB priority.
  always_comb begin
    enc_index = '0;
    enc_multi = 1'b0;
    any_set   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_data[i]) begin
        if (MSB_PRIORITY || !any_set) begin
          enc_index = IDX_W'(i);
        end
        if (any_set) begin
          enc_multi = 1'b1;
        end
        any_set = 1'b1;
      end
    end
    enc_zero = !(s1_en && any_set);
    if (enc_zero) begin
      enc_index = '0;
      enc_multi = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_en    <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= bus.in_data;
      s1_en    <= bus.enable;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Result fields only change on a load so they hold while out_valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_index <= '0;
      s2_zero  <= 1'b0;
      s2_multi <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_index <= enc_index;
      s2_zero  <= enc_zero;
      s2_multi <= enc_multi;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (bus.clear_count) begin
      err_cnt <= '0;
    end else if (out_fire && s2_multi && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_index = s2_index;
  assign bus.out_zero  = s2_zero;
  assign bus.out_multi = s2_multi;
  assign bus.err_count = err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_prio_enc_pipe: self-checking bench for three prio_enc_pipe variants.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_prio_enc_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clear_count;

  always #5 clk = ~clk;

  prio_enc_pipe_if #(.WIDTH(16), .IDX_W(4), .CNT_W(8)) ifa ();
  prio_enc_pipe_if #(.WIDTH(16), .IDX_W(4), .CNT_W(8)) ifb ();
  prio_enc_pipe_if #(.WIDTH(16), .IDX_W(4), .CNT_W(2)) ifc ();

  assign ifa.enable = enable;  assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;
  assign ifa.out_ready = out_ready;  assign ifa.clear_count = clear_count;
  assign ifb.enable = enable;  assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;
  assign ifb.out_ready = out_ready;  assign ifb.clear_count = clear_count;
  assign ifc.enable = enable;  assign ifc.in_valid = in_valid;  assign ifc.in_data = in_data;
  assign ifc.out_ready = out_ready;  assign ifc.clear_count = clear_count;

  prio_enc_pipe #(.WIDTH(16), .IDX_W(4), .MSB_PRIORITY(1'b1), .CNT_W(8)) dut_a (
    .clock(clk), .reset(reset), .bus(ifa.slave));
  prio_enc_pipe #(.WIDTH(16), .IDX_W(4), .MSB_PRIORITY(1'b0), .CNT_W(8)) dut_b (
    .clock(clk), .reset(reset), .bus(ifb.slave));
  prio_enc_pipe #(.WIDTH(16), .IDX_W(4), .MSB_PRIORITY(1'b1), .CNT_W(2)) dut_c (
    .clock(clk), .reset(reset), .bus(ifc.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Expected encoding from arithmetic: log2 for the top bit, two's-complement isolate for the bottom.
  function automatic void enc(input logic [15:0] w, input bit e, input bit msb,
                              output int idx, output bit z, output bit m);
    int wi;
    int lo;
    wi  = int'(w);
    idx = 0;
    z   = 1'b1;
    m   = 1'b0;
    if (e && wi != 0) begin
      z = 1'b0;
      m = ($countones(w) > 1);
      if (msb) begin
        idx = $clog2(wi + 1) - 1;
      end else begin
        lo  = wi & (-wi);
        idx = $clog2(lo);
      end
    end
  endfunction

  typedef struct {
    logic [15:0] w;
    bit          e;
    int          acc;
  } word_t;

  word_t q[$];
  int    edge_n = 0;
  int    cnt8 = 0;
  int    cnt2 = 0;
  int    last_idx[3];
  bit    last_z[3];
  bit    last_m[3];
  bit    in_hs_next = 1'b0;

  always @(posedge clk) begin
    if (!reset) edge_n++;
  end

  always @(negedge clk) begin
    bit exp_v;
    bit pop;
    bit exp_rdy;
    int ix;
    bit zz;
    bit mm;
    word_t nw;
    if (reset) begin
      q.delete();
      cnt8 = 0;
      cnt2 = 0;
      for (int d = 0; d < 3; d++) begin
        last_idx[d] = 0; last_z[d] = 1'b0; last_m[d] = 1'b0;
      end
      in_hs_next = 1'b0;
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_in_ready", ifa.in_ready, 1);
      chk("rst_err_count", ifa.err_count, 0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].acc <= edge_n - 1);
      if (exp_v) begin
        enc(q[0].w, q[0].e, 1'b1, ix, zz, mm);
        last_idx[0] = ix; last_z[0] = zz; last_m[0] = mm;
        last_idx[2] = ix; last_z[2] = zz; last_m[2] = mm;
        enc(q[0].w, q[0].e, 1'b0, ix, zz, mm);
        last_idx[1] = ix; last_z[1] = zz; last_m[1] = mm;
      end
      chk("a_valid", ifa.out_valid, exp_v);
      chk("b_valid", ifb.out_valid, exp_v);
      chk("c_valid", ifc.out_valid, exp_v);
      chk("a_index", ifa.out_index, last_idx[0]);
      chk("b_index", ifb.out_index, last_idx[1]);
      chk("c_index", ifc.out_index, last_idx[2]);
      chk("a_flags", {ifa.out_zero, ifa.out_multi}, {last_z[0], last_m[0]});
      chk("b_flags", {ifb.out_zero, ifb.out_multi}, {last_z[1], last_m[1]});
      chk("c_flags", {ifc.out_zero, ifc.out_multi}, {last_z[2], last_m[2]});
      chk("a_err", ifa.err_count, cnt8);
      chk("b_err", ifb.err_count, cnt8);
      chk("c_err", ifc.err_count, cnt2);
      // Two-word buffer: room exists if fewer than two words remain after this cycle's delivery.
      pop     = exp_v && out_ready;
      exp_rdy = (q.size() - int'(pop)) < 2;
      chk("a_in_ready", ifa.in_ready, exp_rdy);
      chk("b_in_ready", ifb.in_ready, exp_rdy);
      chk("c_in_ready", ifc.in_ready, exp_rdy);
      if (clear_count) begin
        cnt8 = 0;
        cnt2 = 0;
      end else if (pop && last_m[0]) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
      if (pop) void'(q.pop_front());
      in_hs_next = in_valid && exp_rdy;
      if (in_hs_next) begin
        nw.w = in_data; nw.e = enable; nw.acc = edge_n + 1;
        q.push_back(nw);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input bit e);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    enable   = e;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (in_hs_next) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; clear_count = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("init_out_valid", ifa.out_valid, 0);
    chk("init_in_ready", ifa.in_ready, 1);
    chk("init_outputs", {ifa.out_index, ifa.out_zero, ifa.out_multi}, 0);
    chk("init_err", ifa.err_count, 0);
    step();

    // Single-hot, back to back: results two edges after acceptance.
    send(16'h0100, 1'b1);
    send(16'h8000, 1'b1);
    chk("t1_valid", ifa.out_valid, 1);
    chk("t1_idx8", ifa.out_index, 8);
    step();
    chk("t1_idx15", ifa.out_index, 15);
    chk("t1_flags", {ifa.out_zero, ifa.out_multi}, 2'b00);

    // Zero word and disabled encode.
    send(16'h0000, 1'b1);
    send(16'h0020, 1'b0);
    chk("t2_zero_a", {ifa.out_index, ifa.out_zero, ifa.out_multi}, 6'b000010);
    step();
    chk("t2_zero_b", {ifa.out_index, ifa.out_zero, ifa.out_multi}, 6'b000010);
    chk("t2_valid", ifa.out_valid, 1);

    // Multi-hot under both priorities.
    send(16'h0A04, 1'b1);
    step();
    chk("t3_msb_idx", ifa.out_index, 11);
    chk("t3_lsb_idx", ifb.out_index, 2);
    chk("t3_multi", {ifa.out_multi, ifb.out_multi}, 2'b11);
    chk("t3_err_before", ifa.err_count, 0);
    step();
    chk("t3_err_after", ifa.err_count, 1);

    // Backpressure: four words against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        send(16'h0003, 1'b1);
        send(16'h0010, 1'b1);
        send(16'h4000, 1'b1);
        send(16'h0009, 1'b1);
      end
      begin
        repeat (5) step();
        chk("t4_in_ready_low", ifa.in_ready, 0);
        chk("t4_hold_valid", ifa.out_valid, 1);
        chk("t4_hold_idx", ifa.out_index, 1);
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("t4_err", ifa.err_count, 3);

    // Saturation on the 2-bit counter.
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    chk("t5_cleared", ifc.err_count, 0);
    send(16'h0003, 1'b1);
    send(16'hC000, 1'b1);
    send(16'h0A04, 1'b1);
    send(16'h0101, 1'b1);
    send(16'hFFFF, 1'b1);
    repeat (4) step();
    chk("t5_sat2", ifc.err_count, 3);
    chk("t5_cnt8", ifa.err_count, 5);

    // Clear wins over a same-cycle multi-hot delivery.
    send(16'h0A04, 1'b1);
    step();
    chk("t5_pending_multi", {ifa.out_valid, ifa.out_multi}, 2'b11);
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    chk("t5_clear_prio_a", ifa.err_count, 0);
    chk("t5_clear_prio_c", ifc.err_count, 0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", ifa.out_valid, 0);
    chk("t6_rst_ready", ifa.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("t6_no_stale", ifa.out_valid, 0);
    send(16'h0040, 1'b1);
    step();
    chk("t6_recover_idx", ifa.out_index, 6);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prio_enc_pipe.md
Name: prio_enc_pipe

Overview:
- Parametrised, pipelined successor to the 16-to-4 binary encoder.
- Takes a WIDTH-bit request word and produces the index of the winning set bit, with selectable MSB/LSB priority.
- Flags all-zero and multi-hot words and keeps a saturating multi-hot error count.
- Sits between a switch/request register bank and downstream consumers; valid/ready on both sides replaces the bare registered wrapper.

Parameters:
- WIDTH, 16, number of request inputs; any value of 2 or more.
- IDX_W, $clog2(WIDTH), width of the encoded index.
- MSB_PRIORITY, 1: 1 means the highest set bit wins; 0 means the lowest set bit wins.
- CNT_W, 8, width of the multi-hot error counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  encode enable; sampled together with in_data.
- in_valid  in  1  in_data is presented.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  request word.
- out_valid  out  1  result is presented.
- out_ready  in  1  consumer accepts the result.
- out_index  out  IDX_W  winning bit index.
- out_zero  out  1  accepted word had no set bit, or enable was low.
- out_multi  out  1  accepted word had 2 or more set bits.
- err_count  out  CNT_W  saturating count of delivered multi-hot results.
- clear_count  in  1  synchronous clear of err_count.

Behaviour:
- Reset (asynchronous, immediate): s1_valid=0, s2_valid=0, in_ready=1, out_valid=0, out_index=0, out_zero=0, out_multi=0, err_count=0. Data registers are also cleared.
- Stage 1 registers in_data and enable on an input handshake (in_valid and in_ready).
- Stage 2 registers the encoded result {index, zero, multi} computed from the stage-1 contents.
- Outputs are driven directly from stage-2 registers; no combinational path from in_data to any output.
- Stage advance:
  - s2_load = s1_valid and (not s2_valid or out_ready).
  - in_ready = not s1_valid or s2_load.
  - This is a combinational path from out_ready to in_ready and is permitted.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N+1 (two registers). Throughput is one word per clock when out_ready is held high.
- Backpressure:
  - While out_valid=1 and out_ready=0, stage-2 contents hold stable and stage 1 holds.
  - in_ready drops once stage 1 is occupied.
  - No word is dropped or duplicated.
- Simultaneous events: a consume at stage 2, a stage-1 to stage-2 move and a new input accept may all occur in the same cycle.
- Encoding of the stage-1 word w, with enable bit e:
  - If e=0 or w=0: index=0, zero=1, multi=0.
  - Otherwise: index = position of the highest set bit (MSB_PRIORITY=1) or lowest set bit (0); zero=0; multi = (popcount(w) > 1).
  - Bits above WIDTH-1 do not exist; when WIDTH is not a power of two, indices are never above WIDTH-1.
- Single-hot input reproduces the plain binary encoder result.
- err_count:
  - Increments by 1 on each output handshake (out_valid and out_ready) where out_multi=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clear_count=1 sets it to 0 at the next edge and takes priority over a same-cycle increment.
- out_index, out_zero and out_multi are don't-care to consumers when out_valid=0 but must hold their last value; they do not toggle.
- Reset mid-operation: all in-flight words are discarded. Nothing appears on the output after reset deasserts until a new word is accepted.

Test Plan:
- WIDTH=16, MSB_PRIORITY=1, enable=1, out_ready=1; send 16'h0100, then 16'h8000 -> out_index 8, then 15; out_zero=0, out_multi=0; each appears 2 edges after acceptance on consecutive cycles.
- Send 16'h0000, then 16'h0020 with enable=0 -> both results have out_index=0, out_zero=1, out_multi=0.
- Send 16'h0A04 with MSB_PRIORITY=1 -> index 11, multi=1. Same word with MSB_PRIORITY=0 -> index 2, multi=1. err_count goes 0->1 at the handshake.
- Stream 4 words with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted; out_valid stays 1 with a stable first result; release -> all 4 results emerge in order with none lost.
- CNT_W=2; deliver 5 multi-hot results -> err_count 1,2,3,3,3. Assert clear_count in the same cycle as a multi-hot handshake -> err_count=0.
- Assert reset while 2 words are in flight -> out_valid=0 and in_ready=1 immediately; no stale result appears after release.
